ft245_chan_mux: RTL and testbench
=================================

Name: ft245_chan_mux

Overview:
- Shares one FT245 byte-stream interface between two client channels.
- Sits between the FT245 interface block and the clients.
- TX: arbitrates client packets round-robin at packet granularity, prefixes each with a header byte, and sequences bytes into the interface.
- RX: parses header bytes from the host, routes payload to the addressed channel, and drops packets with an invalid channel id.

Parameters:
- none (channel count fixed at 2; header format fixed)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ifc_tx_data  out  8  byte to interface TX
- ifc_tx_seq  out  1  toggled to launch one byte
- ifc_tx_ack  in  1  equals ifc_tx_seq when the byte has been taken
- ifc_rx_data  in  8  received byte
- ifc_rx_seq  in  1  toggles when a new byte is ready
- ifc_rx_ack  out  1  set equal to ifc_rx_seq to consume the byte
- c0_tx_data, c1_tx_data  in  8  client payload byte
- c0_tx_len, c1_tx_len  in  4  payload length minus 1; sampled with the first byte of a packet
- c0_tx_seq, c1_tx_seq  in  1  client toggles to offer a byte
- c0_tx_ack, c1_tx_ack  out  1  set to the client seq once the byte has been forwarded
- c0_rx_data, c1_rx_data  out  8  routed payload byte
- c0_rx_last, c1_rx_last  out  1  marks the final byte of a packet; valid with data
- c0_rx_seq, c1_rx_seq  out  1  toggles per delivered byte
- c0_rx_ack, c1_rx_ack  in  1  client sets equal to seq to accept the byte
- err_cnt  out  8  saturating count of dropped RX packets

Behaviour:
- Handshake convention:
  - A byte is pending while seq != ack.
  - The receiver consumes it by copying seq into ack.
  - All outputs are registered.
- Header byte: bits [7:4] = channel id, bits [3:0] = payload length minus 1 (1..16 bytes).
- Reset:
  - All seq/ack outputs 0; all data outputs 0; c*_rx_last 0; err_cnt 0.
  - TX FSM in T_IDLE, RX FSM in R_HDR.
  - last_grant = 1, so channel 0 wins the first tie.
  - Reset mid-packet abandons the packet with no completion. The interface block and clients share the same reset, so all toggles restart from 0.
- TX FSM:
  - T_IDLE:
    - req_n = (cN_tx_seq != cN_tx_ack).
    - Only one request: grant it.
    - Both requesting: grant the channel other than last_grant.
    - On grant: register ifc_tx_data = {3'b000, grant, cN_tx_len}, toggle ifc_tx_seq, load remaining = len, record last_grant, go to T_HDR.
    - The header toggle is visible 1 cycle after the client toggle is seen.
  - T_HDR:
    - Wait for ifc_tx_ack == ifc_tx_seq.
    - Then issue the granted client's pending byte (toggle ifc_tx_seq) and go to T_PAY.
  - T_PAY:
    - Wait for ifc ack, then set cN_tx_ack = cN_tx_seq (1 cycle after the ifc ack).
    - remaining == 0: go to T_IDLE.
    - Else: decrement remaining and go to T_WAIT.
  - T_WAIT:
    - When the granted client has a pending byte, issue it and go to T_PAY.
    - The other channel is never interleaved inside a packet, however long the client stalls.
  - At most one byte is outstanding to the interface at any time.
  - A client toggling seq while its previous byte is unacked is a protocol violation; behaviour is undefined.
- RX FSM (independent of TX; both may run in the same cycle):
  - R_HDR:
    - When an ifc byte is pending, latch chan = bits [7:4] and cnt = bits [3:0], consume it.
    - chan <= 1: go to R_PAY.
    - Otherwise: err_cnt += 1 (saturates at 255), go to R_DROP.
  - R_PAY:
    - Wait until an ifc byte is pending AND the destination client is free (cN_rx_seq == cN_rx_ack).
    - Then drive cN_rx_data = byte, cN_rx_last = (cnt == 0), toggle cN_rx_seq, and consume the ifc byte, all in the same cycle.
    - cnt == 0: go to R_HDR; else decrement cnt.
  - Back-pressure: while the client is busy, ifc_rx_ack is held, so no byte is lost.
  - R_DROP: consume each pending ifc byte without forwarding; after cnt+1 bytes, go to R_HDR.
  - The undestined client's rx outputs never change.

Test Plan:
- Ch0 single packet: c0_tx_len=2, bytes A1,A2,A3 offered one per ack -> ifc sees 0x02,A1,A2,A3 in order; c0_tx_ack follows each byte; FSM returns to T_IDLE.
- Tie: after reset both channels request in the same cycle (len 0, bytes 0xC0, 0xC1) -> ifc sees 0x00,C0 then 0x10,C1; second tie -> ch0 first again.
- No interleave: ch1 len=3 packet stalled 20 cycles between bytes while ch0 requests -> ch0 header appears only after ch1's 4th byte is acked by ifc.
- RX route: ifc delivers 0x11,0x55,0x66 -> c1 gets 0x55 (last=0) then 0x66 (last=1); c0_rx_seq unchanged; err_cnt=0.
- RX drop + back-pressure: ifc delivers 0x30,0xEE then 0x00,0x77 with c0_rx_ack withheld 10 cycles -> err_cnt=1; 0xEE never forwarded; ifc_rx_ack held until c0 accepts; c0 gets 0x77 with last=1.
- Reset mid-TX-packet (after header, before payload) -> all seq/ack outputs 0 next cycle; a subsequent ch1 request is granted with a fresh header.

Source files
------------

// File: rtl/ft245_chan_mux.sv
// ft245_chan_mux: shares one FT245 byte stream between two client channels with header-framed packets
module ft245_chan_mux (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] ifc_tx_data,
    output logic       ifc_tx_seq,
    input  logic       ifc_tx_ack,
    input  logic [7:0] ifc_rx_data,
    input  logic       ifc_rx_seq,
    output logic       ifc_rx_ack,
    input  logic [7:0] c0_tx_data,
    input  logic [3:0] c0_tx_len,
    input  logic       c0_tx_seq,
    output logic       c0_tx_ack,
    input  logic [7:0] c1_tx_data,
    input  logic [3:0] c1_tx_len,
    input  logic       c1_tx_seq,
    output logic       c1_tx_ack,
    output logic [7:0] c0_rx_data,
    output logic       c0_rx_last,
    output logic       c0_rx_seq,
    input  logic       c0_rx_ack,
    output logic [7:0] c1_rx_data,
    output logic       c1_rx_last,
    output logic       c1_rx_seq,
    input  logic       c1_rx_ack,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY, T_WAIT} tx_state_e;
    typedef enum logic [1:0] {R_HDR, R_PAY, R_DROP} rx_state_e;

    tx_state_e  tx_state_q, tx_state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] remaining_q, remaining_d;
    logic [7:0] ifc_tx_data_q, ifc_tx_data_d;
    logic       ifc_tx_seq_q, ifc_tx_seq_d;
    logic       c0_tx_ack_q, c0_tx_ack_d;
    logic       c1_tx_ack_q, c1_tx_ack_d;

    rx_state_e  rx_state_q, rx_state_d;
    logic       rx_chan_q, rx_chan_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ifc_rx_ack_q, ifc_rx_ack_d;
    logic [7:0] c0_rx_data_q, c0_rx_data_d;
    logic       c0_rx_last_q, c0_rx_last_d;
    logic       c0_rx_seq_q, c0_rx_seq_d;
    logic [7:0] c1_rx_data_q, c1_rx_data_d;
    logic       c1_rx_last_q, c1_rx_last_d;
    logic       c1_rx_seq_q, c1_rx_seq_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       req0, req1, pick, g_pending, tx_busy;
    logic [3:0] pick_len;
    logic [7:0] g_data;
    logic       rx_pending, dest_free;

    // TX request decode; in T_IDLE last_grant_q doubles as the round-robin pointer,
    // afterwards it names the channel that owns the current packet
    always_comb begin
        req0      = c0_tx_seq != c0_tx_ack_q;
        req1      = c1_tx_seq != c1_tx_ack_q;
        pick      = (req0 && req1) ? ~last_grant_q : req1;
        pick_len  = pick ? c1_tx_len : c0_tx_len;
        g_pending = last_grant_q ? req1 : req0;
        g_data    = last_grant_q ? c1_tx_data : c0_tx_data;
        tx_busy   = ifc_tx_ack != ifc_tx_seq_q;
    end

    // TX FSM next state: header then payload, one byte outstanding, no interleaving within a packet
    always_comb begin
        tx_state_d    = tx_state_q;
        last_grant_d  = last_grant_q;
        remaining_d   = remaining_q;
        ifc_tx_data_d = ifc_tx_data_q;
        ifc_tx_seq_d  = ifc_tx_seq_q;
        c0_tx_ack_d   = c0_tx_ack_q;
        c1_tx_ack_d   = c1_tx_ack_q;
        case (tx_state_q)
            T_IDLE: begin
                if (req0 || req1) begin
                    ifc_tx_data_d = {3'b000, pick, pick_len};
                    ifc_tx_seq_d  = ~ifc_tx_seq_q;
                    remaining_d   = pick_len;
                    last_grant_d  = pick;
                    tx_state_d    = T_HDR;
                end
            end
            T_HDR: begin
                if (!tx_busy) begin
                    ifc_tx_data_d = g_data;
                    ifc_tx_seq_d  = ~ifc_tx_seq_q;
                    tx_state_d    = T_PAY;
                end
            end
            T_PAY: begin
                if (!tx_busy) begin
                    if (last_grant_q)
                        c1_tx_ack_d = c1_tx_seq;
                    else
                        c0_tx_ack_d = c0_tx_seq;
                    if (remaining_q == 4'd0) begin
                        tx_state_d = T_IDLE;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                        tx_state_d  = T_WAIT;
                    end
                end
            end
            T_WAIT: begin
                if (g_pending) begin
                    ifc_tx_data_d = g_data;
                    ifc_tx_seq_d  = ~ifc_tx_seq_q;
                    tx_state_d    = T_PAY;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // RX status decode: byte waiting from host, and whether the addressed client can take one
    always_comb begin
        rx_pending = ifc_rx_seq != ifc_rx_ack_q;
        dest_free  = rx_chan_q ? (c1_rx_seq_q == c1_rx_ack) : (c0_rx_seq_q == c0_rx_ack);
    end

    // RX FSM next state: parse header, route or drop payload, hold host ack while client is busy
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_chan_d    = rx_chan_q;
        cnt_d        = cnt_q;
        ifc_rx_ack_d = ifc_rx_ack_q;
        c0_rx_data_d = c0_rx_data_q;
        c0_rx_last_d = c0_rx_last_q;
        c0_rx_seq_d  = c0_rx_seq_q;
        c1_rx_data_d = c1_rx_data_q;
        c1_rx_last_d = c1_rx_last_q;
        c1_rx_seq_d  = c1_rx_seq_q;
        err_cnt_d    = err_cnt_q;
        case (rx_state_q)
            R_HDR: begin
                if (rx_pending) begin
                    rx_chan_d    = ifc_rx_data[4];
                    cnt_d        = ifc_rx_data[3:0];
                    ifc_rx_ack_d = ifc_rx_seq;
                    if (ifc_rx_data[7:5] == 3'b000) begin
                        rx_state_d = R_PAY;
                    end else begin
                        err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        rx_state_d = R_DROP;
                    end
                end
            end
            R_PAY: begin
                if (rx_pending && dest_free) begin
                    if (rx_chan_q) begin
                        c1_rx_data_d = ifc_rx_data;
                        c1_rx_last_d = cnt_q == 4'd0;
                        c1_rx_seq_d  = ~c1_rx_seq_q;
                    end else begin
                        c0_rx_data_d = ifc_rx_data;
                        c0_rx_last_d = cnt_q == 4'd0;
                        c0_rx_seq_d  = ~c0_rx_seq_q;
                    end
                    ifc_rx_ack_d = ifc_rx_seq;
                    if (cnt_q == 4'd0)
                        rx_state_d = R_HDR;
                    else
                        cnt_d = cnt_q - 4'd1;
                end
            end
            R_DROP: begin
                if (rx_pending) begin
                    ifc_rx_ack_d = ifc_rx_seq;
                    if (cnt_q == 4'd0)
                        rx_state_d = R_HDR;
                    else
                        cnt_d = cnt_q - 4'd1;
                end
            end
            default: rx_state_d = R_HDR;
        endcase
    end

    // TX state registers; channel 0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q    <= T_IDLE;
            last_grant_q  <= 1'b1;
            remaining_q   <= 4'd0;
            ifc_tx_data_q <= 8'd0;
            ifc_tx_seq_q  <= 1'b0;
            c0_tx_ack_q   <= 1'b0;
            c1_tx_ack_q   <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            last_grant_q  <= last_grant_d;
            remaining_q   <= remaining_d;
            ifc_tx_data_q <= ifc_tx_data_d;
            ifc_tx_seq_q  <= ifc_tx_seq_d;
            c0_tx_ack_q   <= c0_tx_ack_d;
            c1_tx_ack_q   <= c1_tx_ack_d;
        end
    end

    // RX state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q   <= R_HDR;
            rx_chan_q    <= 1'b0;
            cnt_q        <= 4'd0;
            ifc_rx_ack_q <= 1'b0;
            c0_rx_data_q <= 8'd0;
            c0_rx_last_q <= 1'b0;
            c0_rx_seq_q  <= 1'b0;
            c1_rx_data_q <= 8'd0;
            c1_rx_last_q <= 1'b0;
            c1_rx_seq_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_chan_q    <= rx_chan_d;
            cnt_q        <= cnt_d;
            ifc_rx_ack_q <= ifc_rx_ack_d;
            c0_rx_data_q <= c0_rx_data_d;
            c0_rx_last_q <= c0_rx_last_d;
            c0_rx_seq_q  <= c0_rx_seq_d;
            c1_rx_data_q <= c1_rx_data_d;
            c1_rx_last_q <= c1_rx_last_d;
            c1_rx_seq_q  <= c1_rx_seq_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign ifc_tx_data = ifc_tx_data_q;
    assign ifc_tx_seq  = ifc_tx_seq_q;
    assign c0_tx_ack   = c0_tx_ack_q;
    assign c1_tx_ack   = c1_tx_ack_q;
    assign ifc_rx_ack  = ifc_rx_ack_q;
    assign c0_rx_data  = c0_rx_data_q;
    assign c0_rx_last  = c0_rx_last_q;
    assign c0_rx_seq   = c0_rx_seq_q;
    assign c1_rx_data  = c1_rx_data_q;
    assign c1_rx_last  = c1_rx_last_q;
    assign c1_rx_seq   = c1_rx_seq_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ft245_chan_mux.sv
// tb_ft245_chan_mux: directed scenarios for the two-channel FT245 mux
module tb_ft245_chan_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ifc_tx_data;
    logic       ifc_tx_seq;
    logic       ifc_tx_ack;
    logic [7:0] ifc_rx_data;
    logic       ifc_rx_seq;
    logic       ifc_rx_ack;
    logic [7:0] c0_tx_data, c1_tx_data;
    logic [3:0] c0_tx_len, c1_tx_len;
    logic       c0_tx_seq, c1_tx_seq, c0_tx_ack, c1_tx_ack;
    logic [7:0] c0_rx_data, c1_rx_data;
    logic       c0_rx_last, c1_rx_last, c0_rx_seq, c1_rx_seq, c0_rx_ack, c1_rx_ack;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tx_sink_en = 1'b1;
    logic       c0_sink_en = 1'b1;
    logic       c1_sink_en = 1'b1;
    logic [7:0] tx_log[$];
    logic [8:0] c0_log[$];
    logic [8:0] c1_log[$];

    always #5 clk = ~clk;

    ft245_chan_mux dut (
        .clk(clk), .reset(reset),
        .ifc_tx_data(ifc_tx_data), .ifc_tx_seq(ifc_tx_seq), .ifc_tx_ack(ifc_tx_ack),
        .ifc_rx_data(ifc_rx_data), .ifc_rx_seq(ifc_rx_seq), .ifc_rx_ack(ifc_rx_ack),
        .c0_tx_data(c0_tx_data), .c0_tx_len(c0_tx_len), .c0_tx_seq(c0_tx_seq), .c0_tx_ack(c0_tx_ack),
        .c1_tx_data(c1_tx_data), .c1_tx_len(c1_tx_len), .c1_tx_seq(c1_tx_seq), .c1_tx_ack(c1_tx_ack),
        .c0_rx_data(c0_rx_data), .c0_rx_last(c0_rx_last), .c0_rx_seq(c0_rx_seq), .c0_rx_ack(c0_rx_ack),
        .c1_rx_data(c1_rx_data), .c1_rx_last(c1_rx_last), .c1_rx_seq(c1_rx_seq), .c1_rx_ack(c1_rx_ack),
        .err_cnt(err_cnt)
    );

    // host side of the interface TX path: logs and immediately takes each launched byte
    initial begin
        ifc_tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ifc_tx_ack = 1'b0;
            end else if (tx_sink_en && ifc_tx_seq != ifc_tx_ack) begin
                tx_log.push_back(ifc_tx_data);
                ifc_tx_ack = ifc_tx_seq;
            end
        end
    end

    // client 0 receiver
    initial begin
        c0_rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                c0_rx_ack = 1'b0;
            end else if (c0_sink_en && c0_rx_seq != c0_rx_ack) begin
                c0_log.push_back({c0_rx_last, c0_rx_data});
                c0_rx_ack = c0_rx_seq;
            end
        end
    end

    // client 1 receiver
    initial begin
        c1_rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                c1_rx_ack = 1'b0;
            end else if (c1_sink_en && c1_rx_seq != c1_rx_ack) begin
                c1_log.push_back({c1_rx_last, c1_rx_data});
                c1_rx_ack = c1_rx_seq;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc_rx_seq = 1'b0;
        c0_tx_seq = 1'b0;
        c1_tx_seq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tx_log.delete();
        c0_log.delete();
        c1_log.delete();
    endtask

    // client offers len+1 bytes (byte i = bytes[8i+:8]), waiting for each ack, stalling between bytes
    task automatic client_send(input int ch, input logic [3:0] len, input logic [31:0] bytes, input int stall);
        int t;
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) repeat (stall) @(negedge clk);
            if (ch == 0) begin
                c0_tx_data = bytes[8*i +: 8];
                c0_tx_len  = len;
                c0_tx_seq  = ~c0_tx_seq;
            end else begin
                c1_tx_data = bytes[8*i +: 8];
                c1_tx_len  = len;
                c1_tx_seq  = ~c1_tx_seq;
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (((ch == 0) ? (c0_tx_ack !== c0_tx_seq) : (c1_tx_ack !== c1_tx_seq)) && t < 200);
            n_checks++;
            if (((ch == 0) ? c0_tx_ack : c1_tx_ack) !== ((ch == 0) ? c0_tx_seq : c1_tx_seq)) begin
                n_fail++;
                $display("FAIL c%0d_tx_ack byte %0d: ack %b, required %b", ch, i,
                         (ch == 0) ? c0_tx_ack : c1_tx_ack, (ch == 0) ? c0_tx_seq : c1_tx_seq);
            end
        end
    endtask

    // host sends one byte on the interface RX path and waits for it to be consumed
    task automatic ifc_send(input logic [7:0] b);
        int t;
        ifc_rx_data = b;
        ifc_rx_seq  = ~ifc_rx_seq;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ifc_rx_ack !== ifc_rx_seq && t < 100);
        n_checks++;
        if (ifc_rx_ack !== ifc_rx_seq) begin
            n_fail++;
            $display("FAIL ifc_rx_consume %h: ack %b, required %b", b, ifc_rx_ack, ifc_rx_seq);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ifc_tx_data, ifc_tx_seq, c0_tx_ack, c1_tx_ack} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_tx_outputs: got %h, required 0", {ifc_tx_data, ifc_tx_seq, c0_tx_ack, c1_tx_ack});
        end
        n_checks++;
        if ({ifc_rx_ack, c0_rx_data, c0_rx_last, c0_rx_seq, c1_rx_data, c1_rx_last, c1_rx_seq} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_rx_outputs: got %h, required 0",
                     {ifc_rx_ack, c0_rx_data, c0_rx_last, c0_rx_seq, c1_rx_data, c1_rx_last, c1_rx_seq});
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
        end
    endtask

    task automatic test_ch0_single();
        logic [31:0] got;
        tx_sink_en = 1'b0;
        fork
            client_send(0, 4'd2, 32'h00A3A2A1, 0);
            begin
                @(negedge clk);
                n_checks++;
                if (ifc_tx_seq !== 1'b1 || ifc_tx_data !== 8'h02) begin
                    n_fail++;
                    $display("FAIL ch0_header_latency: seq %b data %h, required 1 02", ifc_tx_seq, ifc_tx_data);
                end
                tx_sink_en = 1'b1;
            end
        join
        got = '0;
        foreach (tx_log[i]) got = {got[23:0], tx_log[i]};
        n_checks++;
        if (tx_log.size() != 4 || got !== 32'h02A1A2A3) begin
            n_fail++;
            $display("FAIL ch0_single_stream: %0d bytes %h, required 4 bytes 02a1a2a3", tx_log.size(), got);
        end
        n_checks++;
        if (c0_tx_ack !== 1'b1 || c1_tx_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ch0_single_acks: c0 %b c1 %b, required 1 0", c0_tx_ack, c1_tx_ack);
        end
        tx_log.delete();
    endtask

    task automatic test_tie();
        logic [31:0] got;
        do_reset();
        fork
            client_send(0, 4'd0, 32'h000000C0, 0);
            client_send(1, 4'd0, 32'h000000C1, 0);
        join
        got = '0;
        foreach (tx_log[i]) got = {got[23:0], tx_log[i]};
        n_checks++;
        if (tx_log.size() != 4 || got !== 32'h00C010C1) begin
            n_fail++;
            $display("FAIL tie_first: %0d bytes %h, required 4 bytes 00c010c1", tx_log.size(), got);
        end
        tx_log.delete();
        fork
            client_send(0, 4'd0, 32'h000000C2, 0);
            client_send(1, 4'd0, 32'h000000C3, 0);
        join
        got = '0;
        foreach (tx_log[i]) got = {got[23:0], tx_log[i]};
        n_checks++;
        if (tx_log.size() != 4 || got !== 32'h00C210C3) begin
            n_fail++;
            $display("FAIL tie_second: %0d bytes %h, required 4 bytes 00c210c3", tx_log.size(), got);
        end
        tx_log.delete();
    endtask

    task automatic test_no_interleave();
        logic [55:0] got;
        fork
            client_send(1, 4'd3, 32'hB3B2B1B0, 20);
            begin
                repeat (3) @(negedge clk);
                client_send(0, 4'd0, 32'h000000D0, 0);
            end
        join
        repeat (2) @(negedge clk);
        got = '0;
        foreach (tx_log[i]) got = {got[47:0], tx_log[i]};
        n_checks++;
        if (tx_log.size() != 7 || got !== 56'h13B0B1B2B300D0) begin
            n_fail++;
            $display("FAIL no_interleave: %0d bytes %h, required 7 bytes 13b0b1b2b300d0", tx_log.size(), got);
        end
        tx_log.delete();
    endtask

    task automatic test_rx_route();
        logic c0s;
        c0s = c0_rx_seq;
        ifc_send(8'h11);
        ifc_send(8'h55);
        ifc_send(8'h66);
        repeat (2) @(negedge clk);
        n_checks++;
        if (c1_log.size() != 2 || {c1_log[0], c1_log[1]} !== {1'b0, 8'h55, 1'b1, 8'h66}) begin
            n_fail++;
            $display("FAIL rx_route_c1: %0d entries %h, required 2 entries %h", c1_log.size(),
                     {c1_log[0], c1_log[1]}, {1'b0, 8'h55, 1'b1, 8'h66});
        end
        n_checks++;
        if (c0_rx_seq !== c0s || c0_log.size() != 0) begin
            n_fail++;
            $display("FAIL rx_route_c0_quiet: seq %b entries %0d, required %b 0", c0_rx_seq, c0_log.size(), c0s);
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rx_route_err_cnt: got %0d, required 0", err_cnt);
        end
        c1_log.delete();
    endtask

    task automatic test_rx_drop_bp();
        logic c0s, c1s, held;
        int t;
        c0_sink_en = 1'b0;
        c0s = c0_rx_seq;
        c1s = c1_rx_seq;
        ifc_send(8'h30);
        ifc_send(8'hEE);
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_err_cnt: got %0d, required 1", err_cnt);
        end
        n_checks++;
        if (c0_rx_seq !== c0s || c1_rx_seq !== c1s || c0_log.size() != 0 || c1_log.size() != 0) begin
            n_fail++;
            $display("FAIL drop_not_forwarded: c0_seq %b c1_seq %b, required %b %b", c0_rx_seq, c1_rx_seq, c0s, c1s);
        end
        ifc_send(8'h00);
        ifc_send(8'h77);
        n_checks++;
        if (c0_rx_seq !== ~c0s || c0_rx_data !== 8'h77 || c0_rx_last !== 1'b1) begin
            n_fail++;
            $display("FAIL c0_deliver_77: seq %b data %h last %b, required %b 77 1", c0_rx_seq, c0_rx_data, c0_rx_last, ~c0s);
        end
        ifc_send(8'h00);
        ifc_rx_data = 8'h88;
        ifc_rx_seq  = ~ifc_rx_seq;
        held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ifc_rx_ack === ifc_rx_seq || c0_rx_data !== 8'h77) held = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_hold: ifc_rx_ack %b data %h, required ack held and data 77", ifc_rx_ack, c0_rx_data);
        end
        c0_sink_en = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ifc_rx_ack !== ifc_rx_seq && t < 50);
        repeat (2) @(negedge clk);
        n_checks++;
        if (c0_log.size() != 2 || {c0_log[0], c0_log[1]} !== {1'b1, 8'h77, 1'b1, 8'h88}) begin
            n_fail++;
            $display("FAIL backpressure_release: %0d entries %h, required 2 entries %h", c0_log.size(),
                     {c0_log[0], c0_log[1]}, {1'b1, 8'h77, 1'b1, 8'h88});
        end
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_err_cnt_final: got %0d, required 1", err_cnt);
        end
        c0_log.delete();
    endtask

    task automatic test_reset_mid_tx();
        logic s;
        logic [15:0] got;
        tx_sink_en = 1'b0;
        s = ifc_tx_seq;
        c0_tx_data = 8'hAA;
        c0_tx_len  = 4'd1;
        c0_tx_seq  = ~c0_tx_seq;
        @(negedge clk);
        n_checks++;
        if (ifc_tx_seq !== ~s || ifc_tx_data !== 8'h01) begin
            n_fail++;
            $display("FAIL midtx_header: seq %b data %h, required %b 01", ifc_tx_seq, ifc_tx_data, ~s);
        end
        reset = 1'b1;
        ifc_rx_seq = 1'b0;
        c0_tx_seq = 1'b0;
        c1_tx_seq = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ifc_tx_seq, ifc_rx_ack, c0_tx_ack, c1_tx_ack, c0_rx_seq, c1_rx_seq} !== 6'd0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midtx_reset_outputs: seq/ack %b err %0d, required 000000 0",
                     {ifc_tx_seq, ifc_rx_ack, c0_tx_ack, c1_tx_ack, c0_rx_seq, c1_rx_seq}, err_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        tx_log.delete();
        c0_log.delete();
        c1_log.delete();
        tx_sink_en = 1'b1;
        client_send(1, 4'd0, 32'h0000005A, 0);
        repeat (2) @(negedge clk);
        got = '0;
        foreach (tx_log[i]) got = {got[7:0], tx_log[i]};
        n_checks++;
        if (tx_log.size() != 2 || got !== 16'h105A) begin
            n_fail++;
            $display("FAIL midtx_fresh_packet: %0d bytes %h, required 2 bytes 105a", tx_log.size(), got);
        end
        tx_log.delete();
    endtask

    task automatic test_err_saturate();
        for (int i = 1; i <= 257; i++) begin
            ifc_send(8'hF0);
            ifc_send(8'h00);
            if (i == 254 || i == 255 || i == 257) begin
                n_checks++;
                if (err_cnt !== ((i == 254) ? 8'd254 : 8'd255)) begin
                    n_fail++;
                    $display("FAIL err_saturate after %0d drops: got %0d, required %0d", i, err_cnt,
                             (i == 254) ? 254 : 255);
                end
            end
        end
        n_checks++;
        if (c0_log.size() != 0 || c1_log.size() != 0) begin
            n_fail++;
            $display("FAIL err_saturate_forwarded: c0 %0d c1 %0d entries, required 0 0", c0_log.size(), c1_log.size());
        end
    endtask

    initial begin
        reset       = 1'b1;
        ifc_rx_data = 8'd0;
        ifc_rx_seq  = 1'b0;
        c0_tx_data  = 8'd0;
        c0_tx_len   = 4'd0;
        c0_tx_seq   = 1'b0;
        c1_tx_data  = 8'd0;
        c1_tx_len   = 4'd0;
        c1_tx_seq   = 1'b0;
        test_reset();
        test_ch0_single();
        test_tie();
        test_no_interleave();
        test_rx_route();
        test_rx_drop_bp();
        test_reset_mid_tx();
        test_err_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
